// File: rtl/eu_operand_collector.sv
// Purpose : collects both source operands for the instruction at the head of
//           eu_IQueue (register file read, then result-bus snooping) and
//           issues the complete instruction to the ALU.
// Latency : 3 cycles from the pop to the earliest exec_valid_o. Operands still
//           in flight add one cycle after their broadcast.
// Backpressure: the instruction is held in ISSUE with stable outputs until
//           exec_ready_i. No new pop occurs while an instruction is held,
//           unless the back-to-back option applies.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   instr_*_i               head of eu_IQueue
//   ready_for_next_instr_o  pop strobe to eu_IQueue
//   rf_rd_*                 register file read request and response; the
//                           response arrives one cycle after rf_rd_en_o
//   fwd_*_i                 result broadcast bus
//   exec_*                  valid/ready issue to the ALU
//
// Option macro EU_OPCOLLECT_BACK_TO_BACK_EN: a handshake in ISSUE that sees a
// valid queue head pops it in the same cycle and goes straight to RF_READ.
module eu_operand_collector #(
   parameter int TAG_WIDTH  = 6,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  instr_valid_i,
   input  logic [OP_WIDTH-1:0]   instr_op_i,
   input  logic [TAG_WIDTH-1:0]  instr_srca_tag_i,
   input  logic [TAG_WIDTH-1:0]  instr_srcb_tag_i,
   input  logic [TAG_WIDTH-1:0]  instr_dst_tag_i,
   output logic                  ready_for_next_instr_o,
   output logic                  rf_rd_en_o,
   output logic [TAG_WIDTH-1:0]  rf_rd_tag_a_o,
   output logic [TAG_WIDTH-1:0]  rf_rd_tag_b_o,
   input  logic [DATA_WIDTH-1:0] rf_rd_data_a_i,
   input  logic [DATA_WIDTH-1:0] rf_rd_data_b_i,
   input  logic                  rf_rd_written_a_i,
   input  logic                  rf_rd_written_b_i,
   input  logic                  fwd_valid_i,
   input  logic [TAG_WIDTH-1:0]  fwd_tag_i,
   input  logic [DATA_WIDTH-1:0] fwd_data_i,
   output logic                  exec_valid_o,
   input  logic                  exec_ready_i,
   output logic [OP_WIDTH-1:0]   exec_op_o,
   output logic [DATA_WIDTH-1:0] exec_opa_o,
   output logic [DATA_WIDTH-1:0] exec_opb_o,
   output logic [TAG_WIDTH-1:0]  exec_dst_tag_o
);

   typedef enum logic [1:0] {IDLE, RF_READ, WAIT_OPS, ISSUE} state_t;

   state_t                state_q, state_d;
   logic                  accept;
   logic [OP_WIDTH-1:0]   op_q;
   logic [TAG_WIDTH-1:0]  srca_q, srcb_q, dst_q;
   logic                  a_rdy_q, b_rdy_q, a_rdy_d, b_rdy_d;
   logic [DATA_WIDTH-1:0] a_dat_q, b_dat_q, a_dat_d, b_dat_d;
   logic                  first_wait_q;
   logic                  collecting;
   logic                  a_fwd_hit, b_fwd_hit, a_rf_hit, b_rf_hit;

   assign collecting = (state_q == RF_READ) || (state_q == WAIT_OPS);

   // Zero tags are marked ready when the instruction is latched, so the
   // "not ready" test also excludes them from every capture.
   // Each operand compares against the broadcast on its own, so two
   // operands that share a tag both capture the same broadcast.
   always_comb begin
      a_fwd_hit = collecting && !a_rdy_q && fwd_valid_i && (fwd_tag_i == srca_q);
      b_fwd_hit = collecting && !b_rdy_q && fwd_valid_i && (fwd_tag_i == srcb_q);
      // The read response is valid only in the cycle after RF_READ.
      a_rf_hit  = first_wait_q && !a_rdy_q && rf_rd_written_a_i;
      b_rf_hit  = first_wait_q && !b_rdy_q && rf_rd_written_b_i;
      a_rdy_d   = a_rdy_q || a_fwd_hit || a_rf_hit;
      b_rdy_d   = b_rdy_q || b_fwd_hit || b_rf_hit;
      // A broadcast is newer than the register file copy, so it takes priority.
      a_dat_d   = a_fwd_hit ? fwd_data_i : (a_rf_hit ? rf_rd_data_a_i : a_dat_q);
      b_dat_d   = b_fwd_hit ? fwd_data_i : (b_rf_hit ? rf_rd_data_b_i : b_dat_q);
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (instr_valid_i) begin
               accept  = 1'b1;
               state_d = RF_READ;
            end
         end
         RF_READ:  state_d = WAIT_OPS;
         WAIT_OPS: if (a_rdy_d && b_rdy_d) state_d = ISSUE;
         ISSUE: begin
            if (exec_ready_i) begin
               state_d = IDLE;
`ifdef EU_OPCOLLECT_BACK_TO_BACK_EN
               if (instr_valid_i) begin
                  accept  = 1'b1;
                  state_d = RF_READ;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         op_q         <= '0;
         srca_q       <= '0;
         srcb_q       <= '0;
         dst_q        <= '0;
         a_rdy_q      <= 1'b0;
         b_rdy_q      <= 1'b0;
         a_dat_q      <= '0;
         b_dat_q      <= '0;
         first_wait_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         first_wait_q <= (state_q == RF_READ);
         if (accept) begin
            op_q    <= instr_op_i;
            srca_q  <= instr_srca_tag_i;
            srcb_q  <= instr_srcb_tag_i;
            dst_q   <= instr_dst_tag_i;
            a_rdy_q <= (instr_srca_tag_i == '0);
            b_rdy_q <= (instr_srcb_tag_i == '0);
            a_dat_q <= '0;
            b_dat_q <= '0;
         end else begin
            a_rdy_q <= a_rdy_d;
            b_rdy_q <= b_rdy_d;
            a_dat_q <= a_dat_d;
            b_dat_q <= b_dat_d;
         end
      end
   end

   // All outputs are forced low while reset_n is held low, so the
   // reset cycle itself shows a quiet interface.
   assign ready_for_next_instr_o = reset_n && accept;
   assign rf_rd_en_o             = reset_n && (state_q == RF_READ);
   assign rf_rd_tag_a_o          = rf_rd_en_o ? srca_q : '0;
   assign rf_rd_tag_b_o          = rf_rd_en_o ? srcb_q : '0;
   assign exec_valid_o           = reset_n && (state_q == ISSUE);
   assign exec_op_o              = exec_valid_o ? op_q    : '0;
   assign exec_opa_o             = exec_valid_o ? a_dat_q : '0;
   assign exec_opb_o             = exec_valid_o ? b_dat_q : '0;
   assign exec_dst_tag_o         = exec_valid_o ? dst_q   : '0;

endmodule

// File: tb/tb_eu_operand_collector.sv
module tb_eu_operand_collector;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_valid_i;
   logic [3:0]  instr_op_i;
   logic [5:0]  instr_srca_tag_i, instr_srcb_tag_i, instr_dst_tag_i;
   logic        ready_for_next_instr_o;
   logic        rf_rd_en_o;
   logic [5:0]  rf_rd_tag_a_o, rf_rd_tag_b_o;
   logic [31:0] rf_rd_data_a_i, rf_rd_data_b_i;
   logic        rf_rd_written_a_i, rf_rd_written_b_i;
   logic        fwd_valid_i;
   logic [5:0]  fwd_tag_i;
   logic [31:0] fwd_data_i;
   logic        exec_valid_o;
   logic        exec_ready_i;
   logic [3:0]  exec_op_o;
   logic [31:0] exec_opa_o, exec_opb_o;
   logic [5:0]  exec_dst_tag_o;

   always #5 clk = ~clk;

   eu_operand_collector dut (
      .clk(clk), .reset_n(reset_n),
      .instr_valid_i(instr_valid_i), .instr_op_i(instr_op_i),
      .instr_srca_tag_i(instr_srca_tag_i), .instr_srcb_tag_i(instr_srcb_tag_i),
      .instr_dst_tag_i(instr_dst_tag_i),
      .ready_for_next_instr_o(ready_for_next_instr_o),
      .rf_rd_en_o(rf_rd_en_o), .rf_rd_tag_a_o(rf_rd_tag_a_o), .rf_rd_tag_b_o(rf_rd_tag_b_o),
      .rf_rd_data_a_i(rf_rd_data_a_i), .rf_rd_data_b_i(rf_rd_data_b_i),
      .rf_rd_written_a_i(rf_rd_written_a_i), .rf_rd_written_b_i(rf_rd_written_b_i),
      .fwd_valid_i(fwd_valid_i), .fwd_tag_i(fwd_tag_i), .fwd_data_i(fwd_data_i),
      .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i),
      .exec_op_o(exec_op_o), .exec_opa_o(exec_opa_o), .exec_opb_o(exec_opb_o),
      .exec_dst_tag_o(exec_dst_tag_o)
   );

`ifdef EU_OPCOLLECT_BACK_TO_BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int handshakes = 0;

   // Stimulus for the next cycle.
   bit         d_rst, d_v, d_fv, d_er;
   logic [3:0] d_op;
   logic [5:0] d_ta, d_tb, d_dst, d_ftag;
   logic [31:0] d_fdat;
   bit         rand_rf;

   // Register file contents that the bench presents to the reads.
   logic [31:0] rf_val [64];
   bit          rf_wr  [64];

   // Model: the one instruction held, the cycle it was popped, and for each
   // operand the value it takes and the cycle that value became known.
   bit          m_pend;
   int          m_t0;
   logic [3:0]  m_op;
   logic [5:0]  m_ta, m_tb, m_dst;
   bit          m_ak, m_bk;
   logic [31:0] m_av, m_bv;
   int          m_aat, m_bat;

   // Outputs sampled in the latest cycle, for the directed checks.
   logic        s_ready, s_valid, s_rden;
   logic [31:0] s_opa, s_opb;
   logic [3:0]  s_op;
   logic [5:0]  s_ta, s_tb;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      bit e_valid, e_rden, e_ready;
      @(negedge clk);
      reset_n          = d_rst;
      instr_valid_i    = d_v;
      instr_op_i       = d_op;
      instr_srca_tag_i = d_ta;
      instr_srcb_tag_i = d_tb;
      instr_dst_tag_i  = d_dst;
      fwd_valid_i      = d_fv;
      fwd_tag_i        = d_ftag;
      fwd_data_i       = d_fdat;
      exec_ready_i     = d_er;
      if (m_pend && cyc == m_t0 + 2) begin
         rf_rd_written_a_i = rf_wr[m_ta];
         rf_rd_data_a_i    = rf_val[m_ta];
         rf_rd_written_b_i = rf_wr[m_tb];
         rf_rd_data_b_i    = rf_val[m_tb];
      end else begin
         // Garbage outside the response cycle must be ignored.
         rf_rd_written_a_i = 1'($urandom_range(0, 1));
         rf_rd_written_b_i = 1'($urandom_range(0, 1));
         rf_rd_data_a_i    = $urandom;
         rf_rd_data_b_i    = $urandom;
      end
      #1;
      e_valid = d_rst && m_pend && m_ak && m_bk &&
                (cyc >= imax(m_t0 + 3, imax(m_aat, m_bat) + 1));
      e_rden  = d_rst && m_pend && (cyc == m_t0 + 1);
      e_ready = d_rst && d_v && (!m_pend || (B2B && e_valid && d_er));

      chk("ready_for_next", {31'd0, ready_for_next_instr_o}, {31'd0, e_ready});
      chk("rf_rd_en", {31'd0, rf_rd_en_o}, {31'd0, e_rden});
      chk("exec_valid", {31'd0, exec_valid_o}, {31'd0, e_valid});
      if (e_rden) begin
         chk("rf_tag_a", {26'd0, rf_rd_tag_a_o}, {26'd0, m_ta});
         chk("rf_tag_b", {26'd0, rf_rd_tag_b_o}, {26'd0, m_tb});
      end
      if (e_valid) begin
         chk("exec_op", {28'd0, exec_op_o}, {28'd0, m_op});
         chk("exec_opa", exec_opa_o, m_av);
         chk("exec_opb", exec_opb_o, m_bv);
         chk("exec_dst", {26'd0, exec_dst_tag_o}, {26'd0, m_dst});
      end
      s_ready = ready_for_next_instr_o; s_valid = exec_valid_o; s_rden = rf_rd_en_o;
      s_opa = exec_opa_o; s_opb = exec_opb_o; s_op = exec_op_o;
      s_ta = rf_rd_tag_a_o; s_tb = rf_rd_tag_b_o;

      if (!d_rst) begin
         m_pend = 1'b0;
      end else begin
         if (m_pend && !m_ak) begin
            if (d_fv && d_ftag == m_ta) begin
               m_ak = 1'b1; m_av = d_fdat; m_aat = cyc;
            end else if (cyc == m_t0 + 2 && rf_rd_written_a_i) begin
               m_ak = 1'b1; m_av = rf_rd_data_a_i; m_aat = cyc;
            end
         end
         if (m_pend && !m_bk) begin
            if (d_fv && d_ftag == m_tb) begin
               m_bk = 1'b1; m_bv = d_fdat; m_bat = cyc;
            end else if (cyc == m_t0 + 2 && rf_rd_written_b_i) begin
               m_bk = 1'b1; m_bv = rf_rd_data_b_i; m_bat = cyc;
            end
         end
         if (e_valid && d_er) begin
            m_pend = 1'b0;
            handshakes++;
         end
         if (e_ready) begin
            m_pend = 1'b1; m_t0 = cyc;
            m_op = d_op; m_ta = d_ta; m_tb = d_tb; m_dst = d_dst;
            m_ak = (d_ta == 6'd0); m_av = 32'd0; m_aat = cyc;
            m_bk = (d_tb == 6'd0); m_bv = 32'd0; m_bat = cyc;
            if (rand_rf) begin
               rf_wr[d_ta] = 1'($urandom_range(0, 1)); rf_val[d_ta] = $urandom;
               rf_wr[d_tb] = 1'($urandom_range(0, 1)); rf_val[d_tb] = $urandom;
            end
         end
      end
      cyc++;
   endtask

   task automatic idle_defaults();
      d_rst = 1'b1; d_v = 1'b0; d_fv = 1'b0; d_er = 1'b1;
      d_op = 4'd0; d_ta = 6'd0; d_tb = 6'd0; d_dst = 6'd0;
      d_ftag = 6'd0; d_fdat = 32'd0;
   endtask

   task automatic pop(input logic [3:0] op, input logic [5:0] ta, input logic [5:0] tb,
                      input logic [5:0] dst, input string name);
      d_v = 1'b1; d_op = op; d_ta = ta; d_tb = tb; d_dst = dst;
      step();
      chk(name, {31'd0, s_ready}, 32'd1);
      d_v = 1'b0;
   endtask

   initial begin
      m_pend = 1'b0; rand_rf = 1'b0;
      for (int i = 0; i < 64; i++) begin rf_val[i] = 32'd0; rf_wr[i] = 1'b0; end
      idle_defaults();

      // Reset with a valid head present: no pop may be signalled.
      d_rst = 1'b0; d_v = 1'b1;
      step();
      chk("reset_ready", {31'd0, s_ready}, 32'd0);
      chk("reset_valid", {31'd0, s_valid}, 32'd0);
      step();
      idle_defaults();
      step();

      // Both operands written in the register file.
      rf_val[3] = 32'h11; rf_wr[3] = 1'b1;
      rf_val[5] = 32'h22; rf_wr[5] = 1'b1;
      pop(4'h2, 6'd3, 6'd5, 6'd9, "d1_pop");
      step();
      chk("d1_rden", {31'd0, s_rden}, 32'd1);
      chk("d1_tag_a", {26'd0, s_ta}, 32'd3);
      chk("d1_tag_b", {26'd0, s_tb}, 32'd5);
      step();
      chk("d1_not_yet", {31'd0, s_valid}, 32'd0);
      step();
      chk("d1_valid", {31'd0, s_valid}, 32'd1);
      chk("d1_opa", s_opa, 32'h11);
      chk("d1_opb", s_opb, 32'h22);
      step();

      // Operand b arrives on the broadcast bus; a wrong tag is ignored.
      rf_val[3] = 32'h33; rf_wr[3] = 1'b1; rf_wr[5] = 1'b0;
      pop(4'h3, 6'd3, 6'd5, 6'd1, "d2_pop");
      d_fv = 1'b1; d_ftag = 6'd6; d_fdat = 32'hEE;
      step();
      d_fv = 1'b0;
      step();
      chk("d2_wait1", {31'd0, s_valid}, 32'd0);
      d_fv = 1'b1; d_ftag = 6'd5; d_fdat = 32'hAB;
      step();
      chk("d2_wait2", {31'd0, s_valid}, 32'd0);
      d_fv = 1'b0;
      step();
      chk("d2_valid", {31'd0, s_valid}, 32'd1);
      chk("d2_opa", s_opa, 32'h33);
      chk("d2_opb", s_opb, 32'hAB);
      step();

      // One broadcast satisfies both operands that share a tag.
      rf_wr[7] = 1'b0;
      pop(4'h4, 6'd7, 6'd7, 6'd2, "d3_pop");
      step(); step();
      d_fv = 1'b1; d_ftag = 6'd7; d_fdat = 32'h5;
      step();
      d_fv = 1'b0;
      step();
      chk("d3_valid", {31'd0, s_valid}, 32'd1);
      chk("d3_opa", s_opa, 32'h5);
      chk("d3_opb", s_opb, 32'h5);
      step();
      chk("d3_single_issue", {31'd0, s_valid}, 32'd0);

      // Backpressure with zero-tag operands and a valid head waiting.
      pop(4'hA, 6'd0, 6'd0, 6'd3, "d4_pop");
      d_er = 1'b0;
      step(); step(); step();
      chk("d4_valid", {31'd0, s_valid}, 32'd1);
      d_v = 1'b1; d_op = 4'h6; d_ta = 6'd0; d_tb = 6'd0; d_dst = 6'd4;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("d4_hold_valid", {31'd0, s_valid}, 32'd1);
         chk("d4_hold_op", {28'd0, s_op}, 32'hA);
         chk("d4_hold_opa", s_opa, 32'd0);
         chk("d4_hold_nopop", {31'd0, s_ready}, 32'd0);
      end
      d_er = 1'b1;
      step();
      chk("d4_hs_ready", {31'd0, s_ready}, {31'd0, B2B});
      d_v = 1'b0;
      for (int k = 0; k < 6; k++) step();

      // Reset in the middle of WAIT_OPS abandons the instruction.
      rf_wr[9] = 1'b0; rf_wr[10] = 1'b0;
      pop(4'h1, 6'd9, 6'd10, 6'd5, "d5_pop");
      step(); step(); step();
      d_rst = 1'b0;
      step();
      d_rst = 1'b1;
      step();
      chk("d5_valid", {31'd0, s_valid}, 32'd0);
      chk("d5_rden", {31'd0, s_rden}, 32'd0);
      chk("d5_ready", {31'd0, s_ready}, 32'd0);
      chk("d5_opa", s_opa, 32'd0);
      d_fv = 1'b1; d_ftag = 6'd9; d_fdat = 32'h77;
      step();
      d_fv = 1'b0;
      step();
      chk("d5_no_issue", {31'd0, s_valid}, 32'd0);
      chk("d5_idle_ready", {31'd0, s_ready}, 32'd0);

      // Random traffic against the model.
      rand_rf = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         d_rst  = ($urandom_range(0, 249) != 0);
         d_v    = ($urandom_range(0, 9) < 6);
         d_op   = 4'($urandom);
         d_ta   = 6'($urandom_range(0, 7));
         d_tb   = ($urandom_range(0, 3) == 0) ? d_ta : 6'($urandom_range(0, 7));
         d_dst  = 6'($urandom);
         d_fv   = ($urandom_range(0, 9) < 4);
         d_ftag = 6'($urandom_range(0, 7));
         d_fdat = $urandom;
         d_er   = ($urandom_range(0, 9) < 6);
         step();
      end
      chk("handshakes_seen", {31'd0, handshakes > 100}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eu_operand_collector.md
EU_OPERAND_COLLECTOR -- requirements
Module: eu_operand_collector

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 6, physical register tag width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-003 SHALL have parameter OP_WIDTH, default 4, opcode width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports instr_valid_i / instr_op_i / instr_srca_tag_i / instr_srcb_tag_i / instr_dst_tag_i  input  1/OP_WIDTH/TAG_WIDTH x3  head of eu_IQueue.
REQ-007 SHALL have port ready_for_next_instr_o  output  1  pop strobe to eu_IQueue.
REQ-008 SHALL have ports rf_rd_en_o  output  1, rf_rd_tag_a_o / rf_rd_tag_b_o  output  TAG_WIDTH  register file read request.
REQ-009 SHALL have ports rf_rd_data_a_i / rf_rd_data_b_i  input  DATA_WIDTH, rf_rd_written_a_i / rf_rd_written_b_i  input  1  read data and "already written" flags, one cycle after rf_rd_en_o.
REQ-010 SHALL have ports fwd_valid_i  input  1, fwd_tag_i  input  TAG_WIDTH, fwd_data_i  input  DATA_WIDTH  result broadcast bus.
REQ-011 SHALL have ports exec_valid_o  output  1, exec_ready_i  input  1, exec_op_o  output  OP_WIDTH, exec_opa_o / exec_opb_o  output  DATA_WIDTH, exec_dst_tag_o  output  TAG_WIDTH  issue to ALU.

Function
REQ-012 SHALL implement FSM states IDLE, RF_READ, WAIT_OPS, ISSUE.
REQ-013 IDLE: ready_for_next_instr_o = instr_valid_i (never asserted while instr_valid_i low, since the queue advances on every ready cycle); on instr_valid_i latch op/tags, -> RF_READ.
REQ-014 RF_READ: rf_rd_en_o=1 with latched tags for exactly one cycle; -> WAIT_OPS.
REQ-015 First WAIT_OPS cycle: operand X marked ready and data captured if rf_rd_written_x_i=1.
REQ-016 Any cycle in RF_READ or WAIT_OPS: unready operand X captured from fwd_data_i when fwd_valid_i and fwd_tag_i == src tag; fwd capture wins over same-cycle RF data.
REQ-017 Source tag all-zeros SHALL be ready at latch time with data 0; no RF or fwd capture.
REQ-018 Both operands sharing one tag SHALL both capture from a single matching broadcast.
REQ-019 WAIT_OPS -> ISSUE on the cycle both operands ready (including same-cycle captures); earliest exec_valid_o is 3 cycles after acceptance.
REQ-020 ISSUE: exec_valid_o=1, outputs stable until exec_ready_i; on exec_valid_o & exec_ready_i -> IDLE.
REQ-021 Operand ready flags and data SHALL clear on each new acceptance.
REQ-022 No instruction SHALL be lost or duplicated: exactly one exec handshake per ready_for_next_instr_o pulse.

Reset
REQ-023 On reset_n=0 at posedge: state IDLE, operand ready flags 0, latched fields and data 0.
REQ-024 During/after reset: ready_for_next_instr_o=0 while reset_n=0, rf_rd_en_o=0, exec_valid_o=0, exec_* data 0.
REQ-025 Reset in any state SHALL abandon the held instruction without issuing it.

Configuration
REQ-026 Macro EU_OPCOLLECT_BACK_TO_BACK_EN: when defined, in ISSUE with exec_ready_i=1 and instr_valid_i=1, ready_for_next_instr_o=1 and the new instruction is latched, -> RF_READ directly (no IDLE bubble).
REQ-027 When undefined, ISSUE always returns to IDLE; ready_for_next_instr_o=0 outside IDLE.

Verification
REQ-028 Accept tags a=3,b=5, RF written both (0x11,0x22) -> exec_valid_o 3 cycles after pop, opa=0x11, opb=0x22.
REQ-029 RF written a only; fwd tag 5 data 0xAB two cycles later -> issue next cycle with opb=0xAB; fwd tag 6 ignored.
REQ-030 srca=srcb=7 unwritten, single fwd tag 7 data 0x5 -> both operands 0x5, one issue.
REQ-031 exec_ready_i low 4 cycles in ISSUE -> outputs stable, no pop; then handshake -> IDLE (or RF_READ with macro and valid head).
REQ-032 reset_n low mid WAIT_OPS -> next cycle all outputs 0, IDLE; instr_valid_i low in IDLE -> ready_for_next_instr_o stays 0.
